// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Multi-cycle execute unit fed by ALU control. It computes
//               R-type, I-type and branch results plus the branch-taken flag.
//               Requests and results use valid/ready handshakes. Shifts run
//               one bit per cycle. All other ops finish in one cycle.
//
// Ports       : clk        - rising-edge clock
//               rst_n      - asynchronous active-low reset
//               in_valid   - operation request
//               in_ready   - unit can accept a request (IDLE only)
//               in_a       - operand A (rs1)
//               in_b       - operand B (rs2/imm), shamt = in_b[SHW-1:0]
//               in_ctl     - {branch-invert, op[3:0]}
//               out_valid  - result available (DONE)
//               out_ready  - consumer takes the result
//               out_result - operation result
//               out_zero   - out_result == 0
//               out_taken  - branch condition, out_zero ^ ctl[4]
//
// Config      : ALU_SEQ_FAST_SHIFT_EN - when defined, a barrel shifter
//               replaces the SHIFT state and every op takes one cycle.
//
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [4:0]      in_ctl,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_zero,
    output logic            out_taken
);

    localparam logic [3:0] c_op_add  = 4'd0;
    localparam logic [3:0] c_op_sub  = 4'd8;
    localparam logic [3:0] c_op_sll  = 4'd1;
    localparam logic [3:0] c_op_slt  = 4'd2;
    localparam logic [3:0] c_op_sltu = 4'd3;
    localparam logic [3:0] c_op_xor  = 4'd4;
    localparam logic [3:0] c_op_srl  = 4'd5;
    localparam logic [3:0] c_op_sra  = 4'd13;
    localparam logic [3:0] c_op_or   = 4'd6;
    localparam logic [3:0] c_op_and  = 4'd7;

`ifdef ALU_SEQ_FAST_SHIFT_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DONE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;
`endif

    state_t            r_state;
    state_t            w_next_state;
    logic [XLEN-1:0]   r_result;
    logic              r_zero;
    logic              r_taken;
    logic [XLEN-1:0]   w_alu;
    logic [SHW-1:0]    w_shamt;
    logic              w_lt_s;
    logic              w_lt_u;

    assign w_shamt = in_b[SHW-1:0];
    assign w_lt_s  = $signed(in_a) < $signed(in_b);
    assign w_lt_u  = in_a < in_b;

`ifndef ALU_SEQ_FAST_SHIFT_EN
    logic [XLEN-1:0]   r_work;
    logic [SHW-1:0]    r_cnt;
    logic [4:0]        r_ctl;
    logic [XLEN-1:0]   w_shifted;
    logic              w_is_shift;

    assign w_is_shift = (in_ctl[3:0] == c_op_sll) ||
                        (in_ctl[3:0] == c_op_srl) ||
                        (in_ctl[3:0] == c_op_sra);

    // One-bit step of the iterative shifter; op[3] separates sra from srl.
    always_comb begin
        w_shifted = {1'b0, r_work[XLEN-1:1]};
        if (r_ctl[3:0] == c_op_sll) begin
            w_shifted = {r_work[XLEN-2:0], 1'b0};
        end else if (r_ctl[3]) begin
            w_shifted = {r_work[XLEN-1], r_work[XLEN-1:1]};
        end
    end
`endif

    // Single-cycle result. In the iterative build a shift reaching this path
    // has shamt 0, so its result is operand A unchanged.
    always_comb begin
        w_alu = '0;
        case (in_ctl[3:0])
            c_op_add:  w_alu = in_a + in_b;
            c_op_sub:  w_alu = in_a - in_b;
            c_op_slt:  w_alu = {{(XLEN-1){1'b0}}, w_lt_s};
            c_op_sltu: w_alu = {{(XLEN-1){1'b0}}, w_lt_u};
            c_op_xor:  w_alu = in_a ^ in_b;
            c_op_or:   w_alu = in_a | in_b;
            c_op_and:  w_alu = in_a & in_b;
`ifdef ALU_SEQ_FAST_SHIFT_EN
            c_op_sll:  w_alu = in_a << w_shamt;
            c_op_srl:  w_alu = in_a >> w_shamt;
            c_op_sra:  w_alu = $unsigned($signed(in_a) >>> w_shamt);
`else
            c_op_sll:  w_alu = in_a;
            c_op_srl:  w_alu = in_a;
            c_op_sra:  w_alu = in_a;
`endif
            default:   w_alu = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
`ifdef ALU_SEQ_FAST_SHIFT_EN
                    w_next_state = S_DONE;
`else
                    if (w_is_shift && (w_shamt != '0)) begin
                        w_next_state = S_SHIFT;
                    end else begin
                        w_next_state = S_DONE;
                    end
`endif
                end
            end
`ifndef ALU_SEQ_FAST_SHIFT_EN
            S_SHIFT: begin
                if (r_cnt == SHW'(1)) begin
                    w_next_state = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath. Results are captured on the same edge that enters DONE so
    // out_zero/out_taken rise together with out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_zero   <= 1'b1;
            r_taken  <= 1'b0;
`ifndef ALU_SEQ_FAST_SHIFT_EN
            r_work   <= '0;
            r_cnt    <= '0;
            r_ctl    <= '0;
`endif
        end else begin
            if ((r_state == S_IDLE) && in_valid) begin
`ifndef ALU_SEQ_FAST_SHIFT_EN
                r_work <= in_a;
                r_cnt  <= w_shamt;
                r_ctl  <= in_ctl;
`endif
                if (w_next_state == S_DONE) begin
                    r_result <= w_alu;
                    r_zero   <= (w_alu == '0);
                    r_taken  <= (w_alu == '0) ^ in_ctl[4];
                end
            end
`ifndef ALU_SEQ_FAST_SHIFT_EN
            if (r_state == S_SHIFT) begin
                r_work <= w_shifted;
                r_cnt  <= r_cnt - SHW'(1);
                // Final shift: publish the shifted value directly.
                if (r_cnt == SHW'(1)) begin
                    r_result <= w_shifted;
                    r_zero   <= (w_shifted == '0);
                    r_taken  <= (w_shifted == '0) ^ r_ctl[4];
                end
            end
`endif
        end
    end

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = (r_state == S_DONE);
    assign out_result = r_result;
    assign out_zero   = r_zero;
    assign out_taken  = r_taken;

endmodule
`default_nettype wire
